// File: rtl/musa_flags_pkg.sv
// Condition-flag codes and branch-unit state shared between the ALU and the branch flag unit.
package musa_flags_pkg;

    localparam int unsigned FlagW = 3;

    typedef enum logic [FlagW-1:0] {
        FlagNone      = 3'b000,
        FlagEqual     = 3'b001,
        FlagException = 3'b010,
        FlagOverflow  = 3'b011,
        FlagUnderflow = 3'b100,
        FlagAbove     = 3'b101
    } flag_e;

    typedef enum logic [0:0] {
        StIdle,
        StFlush
    } bfu_state_e;

    localparam int unsigned FlushCntW = 3;

    // Codes above the last defined flag are never stored; they collapse to NONE.
    function automatic logic [FlagW-1:0] sanitize_flag(input logic [FlagW-1:0] code);
        logic [FlagW-1:0] above;
        above = FlagAbove;
        return (code > above) ? FlagW'(FlagNone) : code;
    endfunction

endpackage

// File: rtl/flag_register.sv
// Architectural flag register: write enable, squash override, synchronous active-low reset.
module flag_register #(
    parameter int unsigned Width = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic             squash_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q;
    logic [Width-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (we_i && !squash_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/branch_flag_unit.sv
// Latches ALU flag codes and resolves BRFL branches into a PC-load pulse plus flush window.
// Define BRFL_FLAG_FORWARD_EN to forward a same-cycle flag write into the compare instead of stalling.
module branch_flag_unit
    import musa_flags_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flag_valid_i,
    input  logic [FlagW-1:0]  flag_in_i,
    input  logic              brfl_valid_i,
    input  logic [FlagW-1:0]  brfl_cond_i,
    input  logic [ADDR_W-1:0] brfl_target_i,
    output logic              brfl_ready_o,
    output logic              branch_taken_o,
    output logic [ADDR_W-1:0] branch_target_o,
    output logic              flush_o,
    output logic [FlagW-1:0]  flag_q_o
);

    localparam logic [FlushCntW-1:0] FlushLoad = FlushCntW'(FLUSH_CYCLES - 1);

    bfu_state_e           state_q;
    logic [FlushCntW-1:0] count_q;
    logic                 branch_taken_q;
    logic [ADDR_W-1:0]    branch_target_q;
    logic                 flush_q;

    logic [FlagW-1:0] flag_q;
    logic [FlagW-1:0] flag_wdata;
    logic [FlagW-1:0] eff_flag;
    logic             ready_idle;
    logic             in_idle;
    logic             accept;
    logic             hit;

    assign in_idle    = (state_q == StIdle);
    assign flag_wdata = sanitize_flag(flag_in_i);

`ifdef BRFL_FLAG_FORWARD_EN
    // The flag writer is the older instruction, so its result is what the branch must see.
    assign ready_idle = 1'b1;
    assign eff_flag   = flag_valid_i ? flag_wdata : flag_q;
`else
    assign ready_idle = ~flag_valid_i;
    assign eff_flag   = flag_q;
`endif

    assign brfl_ready_o = in_idle & ready_idle;
    assign accept       = brfl_valid_i & brfl_ready_o;
    assign hit          = (eff_flag == brfl_cond_i);

    flag_register #(
        .Width (FlagW)
    ) u_flag_register (
        .clk_i    (clock),
        .rst_ni   (reset),
        .we_i     (flag_valid_i),
        .squash_i (~in_idle),
        .d_i      (flag_wdata),
        .q_o      (flag_q)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= StIdle;
            count_q         <= '0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            flush_q         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept && hit) begin
                        state_q         <= StFlush;
                        count_q         <= FlushLoad;
                        branch_taken_q  <= 1'b1;
                        branch_target_q <= brfl_target_i;
                        flush_q         <= 1'b1;
                    end else begin
                        branch_taken_q  <= 1'b0;
                    end
                end
                StFlush: begin
                    branch_taken_q <= 1'b0;
                    if (count_q == '0) begin
                        flush_q <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign branch_taken_o  = branch_taken_q;
    assign branch_target_o = branch_target_q;
    assign flush_o         = flush_q;
    assign flag_q_o        = flag_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Randomized bench for branch_flag_unit against a cycle-count reference model.
module tb_branch_flag_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned FC = 2;
`ifdef BRFL_FLAG_FORWARD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          flag_valid;
    logic [2:0]    flag_in;
    logic          brfl_valid;
    logic [2:0]    brfl_cond;
    logic [AW-1:0] brfl_target;
    logic          brfl_ready;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          flush;
    logic [2:0]    flag_q;

    branch_flag_unit #(
        .ADDR_W       (AW),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .flag_valid_i    (flag_valid),
        .flag_in_i       (flag_in),
        .brfl_valid_i    (brfl_valid),
        .brfl_cond_i     (brfl_cond),
        .brfl_target_i   (brfl_target),
        .brfl_ready_o    (brfl_ready),
        .branch_taken_o  (branch_taken),
        .branch_target_o (branch_target),
        .flush_o         (flush),
        .flag_q_o        (flag_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: stored flag, flush cycles still to come, last pulse and target.
    int unsigned  m_flag;
    int           m_flush_left;
    bit           m_taken;
    longint unsigned m_target;

    task automatic check_eq(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned legal(input int unsigned code);
        return (code > 5) ? 0 : code;
    endfunction

    function automatic bit model_ready(input bit fv);
        return (m_flush_left == 0) && (Fwd || !fv);
    endfunction

    task automatic model_reset();
        m_flag       = 0;
        m_flush_left = 0;
        m_taken      = 1'b0;
        m_target     = 0;
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance model across the edge.
    task automatic step(input bit fv, input int unsigned fin, input bit bv,
                        input int unsigned cond, input logic [AW-1:0] tgt, input bit rst_n);
        bit          rdy;
        int unsigned eff;
        flag_valid  = fv;
        flag_in     = 3'(fin);
        brfl_valid  = bv;
        brfl_cond   = 3'(cond);
        brfl_target = tgt;
        reset       = rst_n;
        #1;
        rdy = model_ready(fv);
        check_eq("flag_q", AW'(flag_q), AW'(m_flag));
        check_eq("flush", AW'(flush), AW'(m_flush_left > 0));
        check_eq("branch_taken", AW'(branch_taken), AW'(m_taken));
        check_eq("branch_target", branch_target, AW'(m_target));
        check_eq("brfl_ready", AW'(brfl_ready), AW'(rdy));
        @(posedge clock);
        if (!rst_n) begin
            model_reset();
        end else if (m_flush_left > 0) begin
            m_flush_left--;
            m_taken = 1'b0;
        end else begin
            eff = (Fwd && fv) ? legal(fin) : m_flag;
            if (fv) m_flag = legal(fin);
            if (bv && rdy && eff == cond) begin
                m_taken      = 1'b1;
                m_target     = tgt;
                m_flush_left = FC;
            end else begin
                m_taken = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 1);
    endtask

    initial begin
        flag_valid  = 1'b0;
        flag_in     = '0;
        brfl_valid  = 1'b0;
        brfl_cond   = '0;
        brfl_target = '0;
        reset       = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();

        // Reset held with a pending flag write.
        step(1, 5, 0, 0, '0, 0);
        step(1, 5, 0, 0, '0, 0);
        idle(1);

        // Taken branch to 0x40.
        step(1, 1, 0, 0, '0, 1);
        step(0, 0, 1, 1, 32'h0000_0040, 1);
        check_eq("taken_pulse", AW'(branch_taken), AW'(1));
        check_eq("taken_target", branch_target, 32'h0000_0040);
        idle(4);

        // Not taken, then back-to-back BRFLs.
        step(1, 5, 0, 0, '0, 1);
        step(0, 0, 1, 1, 32'h100, 1);
        step(0, 0, 1, 2, 32'h200, 1);
        check_eq("not_taken_ready", AW'(brfl_ready), AW'(1));
        step(0, 0, 1, 5, 32'h300, 1);
        idle(3);

        // Same-cycle flag write and BRFL, held until accepted.
        step(1, 3, 1, 3, 32'h400, 1);
        step(0, 0, 1, 3, 32'h400, 1);
        idle(3);

        // Wrong-path flag writes during flush, plus an illegal code.
        step(1, 6, 0, 0, '0, 1);
        step(0, 0, 1, 0, 32'h500, 1);
        step(1, 4, 0, 0, '0, 1);
        step(1, 4, 1, 4, 32'h600, 1);
        idle(2);

        // Reset during the second flush cycle.
        step(1, 2, 0, 0, '0, 1);
        step(0, 0, 1, 2, 32'h700, 1);
        step(0, 0, 0, 0, '0, 1);
        step(0, 0, 0, 0, '0, 0);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            bit          fv;
            bit          bv;
            int unsigned fin;
            int unsigned cond;
            fv   = ($urandom_range(0, 2) == 0);
            bv   = ($urandom_range(0, 1) == 0);
            fin  = $urandom_range(0, 7);
            cond = ($urandom_range(0, 1) == 0) ? (fv ? legal(fin) : m_flag) : $urandom_range(0, 7);
            step(fv, fin, bv, cond, AW'($urandom), ($urandom_range(0, 60) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
